// File: rtl/cla16_multiword_seq_ctrl.sv
// cla16_multiword_seq_ctrl
//   Wide adder that reuses one 16-bit carry-lookahead slice over WORDS
//   clocks, least-significant slice first, with the slice carry kept in
//   a register between clocks.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled only in IDLE or DONE
//   a, b   16*WORDS-bit operands, captured when start is accepted
//   cin    carry-in, captured when start is accepted
//   busy   high while slices are processed (RUN)
//   done   one-cycle pulse, result valid
//   sum    registered 16*WORDS-bit result
//   cout   registered final carry-out
//   ovf    signed overflow flag; real only when CLA_SEQ_OVF_EN is defined,
//          otherwise tied to 0
//
// State table:
//   S_IDLE | waiting for start
//   S_RUN  | one slice per clock, idx_q selects the slice
//   S_DONE | result valid, done pulse; start here is accepted back-to-back

module cla16_multiword_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W+3:0] shamt;
    logic [15:0]      sl_a, sl_b, sl_g, sl_p, sl_sum;
    logic [16:0]      sl_c;
    logic [3:0]       grp_g, grp_p;
    logic [4:0]       grp_c;

    // 16-bit CLA slice: 4-bit groups with a second lookahead level.
    always_comb begin
        shamt  = {idx_q, 4'b0000};
        sl_a   = 16'(a_q >> shamt);
        sl_b   = 16'(b_q >> shamt);
        sl_g   = sl_a & sl_b;
        sl_p   = sl_a ^ sl_b;
        for (int j = 0; j < 4; j++) begin
            grp_g[j] = sl_g[4*j+3]
                     | (sl_p[4*j+3] & sl_g[4*j+2])
                     | (sl_p[4*j+3] & sl_p[4*j+2] & sl_g[4*j+1])
                     | (sl_p[4*j+3] & sl_p[4*j+2] & sl_p[4*j+1] & sl_g[4*j]);
            grp_p[j] = &sl_p[4*j +: 4];
        end
        grp_c[0] = carry_q;
        grp_c[1] = grp_g[0] | (grp_p[0] & carry_q);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (&grp_p[1:0] & carry_q);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (&grp_p[2:1] & grp_g[0])
                 | (&grp_p[2:0] & carry_q);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (&grp_p[3:2] & grp_g[1])
                 | (&grp_p[3:1] & grp_g[0]) | (&grp_p[3:0] & carry_q);
        sl_c = '0;
        for (int j = 0; j < 4; j++) begin
            sl_c[4*j] = grp_c[j];
            for (int i = 0; i < 3; i++) begin
                sl_c[4*j+i+1] = sl_g[4*j+i] | (sl_p[4*j+i] & sl_c[4*j+i]);
            end
        end
        sl_c[16] = grp_c[4];
        sl_sum   = sl_p ^ sl_c[15:0];
    end

`ifdef CLA_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~(W'(16'hFFFF) << shamt)) | (W'(sl_sum) << shamt);
                carry_d = sl_c[16];
                if (idx_q == IDX_LAST) begin
                    // idx is left alone here so it never wraps
                    cout_d  = sl_c[16];
                    state_d = S_DONE;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = sl_c[15] ^ sl_c[16];
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_cla16_multiword_seq_ctrl.sv
module tb_cla16_multiword_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc_cnt  = 0;

    logic [W+1:0] sb_q[$];

    cla16_multiword_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
        logic [W:0] full;
        logic       c_in_msb, v;
        full     = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        c_in_msb = x[W-1] ^ y[W-1] ^ full[W-1];
`ifdef CLA_SEQ_OVF_EN
        v = c_in_msb ^ full[W];
`else
        v = 1'b0 & c_in_msb;
`endif
        return {full[W-1:0], full[W], v};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("sb_empty", 80'(sb_q.size()), 80'd1);
            else chk("result", {sum, cout, ovf}, sb_q.pop_front());
        end
    end

    // Drive one request at the current negedge and wait for its done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input string tag);
        int cyc, bcyc;
        a = x; b = y; cin = ci; start = 1'b1;
        sb_q.push_back(model(x, y, ci));
        cyc = 0; bcyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) bcyc++;
        end while (!done && cyc < 30);
        chk({tag, "_latency"}, 80'(cyc), 80'(WORDS + 1));
        chk({tag, "_busy"}, 80'(bcyc), 80'(WORDS));
        @(negedge clk);
    endtask

    initial begin
        int d0, t1, cyc;
        logic [W-1:0] y_a, y_b;

        // 1: reset with start held high
        rst = 1'b1; start = 1'b1; cin = 1'b1; a = '1; b = '1;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_done", 80'(done), 80'd0);
        chk("rst_sum",  80'(sum),  80'd0);
        chk("rst_cout", 80'(cout), 80'd0);
        chk("rst_ovf",  80'(ovf),  80'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_nostart", 80'(busy), 80'd0);

        // 2, 3: directed adds
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "ones_plus_one");
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, "comp_cin0");
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, "comp_cin1");
        for (int i = 0; i < 4; i++)
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rand");

        // 4: start and operand changes during RUN are ignored
        d0 = done_cnt;
        a = 64'h8000_0000_0000_1234; b = 64'h8000_0000_0000_4321; cin = 1'b0; start = 1'b1;
        sb_q.push_back(model(a, b, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk); a = 64'h1111; b = 64'h2222; cin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin @(negedge clk); cyc++; end
        chk("ign_timeout", 80'(done), 80'd1);
        repeat (8) @(negedge clk);
        chk("ign_one_done", 80'(done_cnt - d0), 80'd1);

        // 5: reset while idx == 2
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b1; start = 1'b1;
        sb_q.push_back(model(a, b, 1'b1));
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy", 80'(busy), 80'd1);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("midrst_busy", 80'(busy), 80'd0);
        chk("midrst_done", 80'(done), 80'd0);
        chk("midrst_sum",  80'(sum),  80'd0);
        chk("midrst_cout", 80'(cout), 80'd0);
        chk("midrst_ovf",  80'(ovf),  80'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 80'(busy), 80'd0);
        run_op(64'd5, 64'd7, 1'b0, "five_seven");

        // 6: back-to-back with start held high through DONE
        y_a = 64'h7FFF_FFFF_FFFF_FFFF; y_b = 64'h1;
        a = 64'hDEAD_BEEF_0000_FFFF; b = 64'h0000_0001_FFFF_0001; cin = 1'b0; start = 1'b1;
        sb_q.push_back(model(a, b, 1'b0));
        @(negedge clk);
        a = y_a; b = y_b; cin = 1'b0;
        sb_q.push_back(model(y_a, y_b, 1'b0));
        cyc = 0;
        while (!done && cyc < 30) begin @(negedge clk); cyc++; end
        chk("b2b_first", 80'(done), 80'd1);
        t1 = cyc_cnt;
        @(negedge clk); start = 1'b0;
        chk("b2b_accept", 80'(busy), 80'd1);
        cyc = 0;
        while (!done && cyc < 30) begin @(negedge clk); cyc++; end
        chk("b2b_second", 80'(done), 80'd1);
        chk("b2b_period", 80'(cyc_cnt - t1), 80'(WORDS + 1));
        repeat (3) @(negedge clk);
        chk("b2b_hold_sum", 80'(sum), 80'(64'h8000_0000_0000_0000));
        chk("sb_drained", 80'(sb_q.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
